// File: rtl/serial_tx_master_if.sv
// Payload, control and SFP-side signals of the 8b10b serial transmitter.
// master: transmitter side; slave: the logic that feeds it and watches the line.
interface serial_tx_master_if;
    logic       i_tx_en;
    logic       i_IsPro;
    logic       i_IsMaster;
    logic       i_RawPls;
    logic [2:0] i_Option;
    logic       i_inj_err;
    logic       o_SerialData;
    logic       o_tx_dis;
    logic       o_sym_strobe;
    logic       o_tx_led;

    modport master (
        input  i_tx_en, i_IsPro, i_IsMaster, i_RawPls, i_Option, i_inj_err,
        output o_SerialData, o_tx_dis, o_sym_strobe, o_tx_led
    );

    modport slave (
        output i_tx_en, i_IsPro, i_IsMaster, i_RawPls, i_Option, i_inj_err,
        input  o_SerialData, o_tx_dis, o_sym_strobe, o_tx_led
    );
endinterface

// File: rtl/serial_tx_master.sv
// 8b10b frame serialiser: one K28.5 comma then SYMS_PER_FRAME-1 parity-protected payload symbols.
// Define SERIAL_TX_ERR_INJ_EN to enable one-shot P0 corruption requested by an i_inj_err edge.
module serial_tx_master #(
    parameter int unsigned CLK_PER_BIT    = 4,
    parameter int unsigned SYMS_PER_FRAME = 256
) (
    input  logic               i_clk,
    input  logic               i_res_n,
    serial_tx_master_if.master bus
);
    localparam int unsigned TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int unsigned SW = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(CLK_PER_BIT - 1);
    localparam logic [SW-1:0] SymLast   = SW'(SYMS_PER_FRAME - 1);
    localparam logic [9:0]    K28p5Neg  = 10'b0011111010;
    localparam logic [9:0]    K28p5Pos  = 10'b1100000101;

    typedef enum logic [1:0] {StIdle, StComma, StData} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;
    logic [SW-1:0] sym_cnt_q, sym_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [7:0]    payload_q, payload_d;
    logic          rd_q, rd_d;
    logic          strobe_q, strobe_d;
    logic          data_load;
    logic          inv_p0;
    logic [7:0]    cur_byte;
    logic [10:0]   enc;

    // Returns {rd_after, abcdei, fghj}; rd = 1 means RD+.
    function automatic logic [10:0] encode(input logic [7:0] d, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd6;
        logic       alt7;
        x = d[4:0];
        y = d[7:5];
        case (x)
            5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;
            5'd3:  c6 = 6'b110001;  5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
            5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;  5'd8:  c6 = 6'b111001;
            5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;
            5'd15: c6 = 6'b010111;  5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
            5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;  5'd20: c6 = 6'b001011;
            5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;
            5'd27: c6 = 6'b110110;  5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
            5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
        endcase
        // Unbalanced codes and D.7 use the complemented form under RD+.
        if (rd && (($countones(c6) != 3) || (x == 5'd7))) c6 = ~c6;
        rd6  = ($countones(c6) != 3) ? ~rd : rd;
        // A7 avoids a run of five equal bits across the 6b/4b boundary.
        alt7 = rd6 ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                   : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
        case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = alt7 ? 4'b0111 : 4'b1110;
        endcase
        if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) c4 = ~c4;
        return {(($countones(c4) != 2) ? ~rd6 : rd6), c6, c4};
    endfunction

`ifdef SERIAL_TX_ERR_INJ_EN
    logic inj_q;
    logic armed_q, armed_d;

    // Once armed, further edges are ignored until a data symbol consumes the request.
    always_comb armed_d = armed_q ? ~data_load : (bus.i_inj_err & ~inj_q);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            inj_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            inj_q   <= bus.i_inj_err;
            armed_q <= armed_d;
        end
    end

    assign inv_p0 = armed_q;
`else
    logic unused_inj;
    assign unused_inj = bus.i_inj_err;
    assign inv_p0     = 1'b0;
`endif

    assign cur_byte = {bus.i_IsPro, bus.i_IsMaster, bus.i_RawPls,
                       ~(bus.i_IsPro ^ bus.i_IsMaster ^ bus.i_RawPls),
                       bus.i_Option, ~(^bus.i_Option) ^ inv_p0};
    assign enc      = encode(cur_byte, rd_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        sym_cnt_d = sym_cnt_q;
        shift_d   = shift_q;
        payload_d = payload_q;
        rd_d      = rd_q;
        strobe_d  = 1'b0;
        data_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                rd_d = 1'b0;
                if (bus.i_tx_en) begin
                    state_d   = StComma;
                    timer_d   = '0;
                    bit_d     = '0;
                    sym_cnt_d = '0;
                    shift_d   = K28p5Neg;
                    rd_d      = 1'b1;
                    strobe_d  = 1'b1;
                end
            end
            StComma, StData: begin
                if (timer_q != TimerLast) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {shift_q[8:0], 1'b0};
                    end else begin
                        bit_d = '0;
                        if (!bus.i_tx_en) begin
                            state_d   = StIdle;
                            sym_cnt_d = '0;
                            shift_d   = '0;
                            rd_d      = 1'b0;
                        end else if (sym_cnt_q == SymLast) begin
                            state_d   = StComma;
                            sym_cnt_d = '0;
                            shift_d   = rd_q ? K28p5Pos : K28p5Neg;
                            rd_d      = ~rd_q;
                            strobe_d  = 1'b1;
                        end else begin
                            state_d   = StData;
                            sym_cnt_d = sym_cnt_q + SW'(1);
                            shift_d   = enc[9:0];
                            rd_d      = enc[10];
                            payload_d = cur_byte;
                            strobe_d  = 1'b1;
                            data_load = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_q     <= '0;
            sym_cnt_q <= '0;
            shift_q   <= '0;
            payload_q <= '0;
            rd_q      <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            sym_cnt_q <= sym_cnt_d;
            shift_q   <= shift_d;
            payload_q <= payload_d;
            rd_q      <= rd_d;
            strobe_q  <= strobe_d;
        end
    end

    assign bus.o_SerialData = shift_q[9];
    assign bus.o_sym_strobe = strobe_q;
    assign bus.o_tx_dis     = (state_q == StIdle);
    assign bus.o_tx_led     = (state_q != StIdle);
endmodule

// File: tb/tb_serial_tx_master.sv
// Randomised bench for serial_tx_master: cycle-level timeline model plus an independent line decoder.
module tb_serial_tx_master;
    localparam int unsigned CPB     = 4;
    localparam int unsigned SPF     = 256;
    localparam int unsigned SYM_CYC = 10 * CPB;
    localparam logic [9:0]  K_NEG   = 10'b0011111010;
    localparam logic [9:0]  K_POS   = 10'b1100000101;
`ifdef SERIAL_TX_ERR_INJ_EN
    localparam int EXP_PAR = 1;
`else
    localparam int EXP_PAR = 0;
`endif

    // 5b6b and 3b4b code tables, RD- and RD+ columns written out in full.
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b0001};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    serial_tx_master_if bus ();

    serial_tx_master #(
        .CLK_PER_BIT    (CPB),
        .SYMS_PER_FRAME (SPF)
    ) dut (
        .i_clk   (clk),
        .i_res_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_byte(input logic pro, input logic mas, input logic raw,
                                          input logic [2:0] opt);
        return {pro, mas, raw, ~(pro ^ mas ^ raw), opt, ~(^opt)};
    endfunction

    // Returns {rd_after, code}; rd = 1 means RD+.
    function automatic logic [10:0] m_enc(input logic [7:0] b, input logic rd);
        logic [5:0] c6;
        logic [3:0] c4;
        logic       r;
        int         x;
        int         y;
        x  = int'(b[4:0]);
        y  = int'(b[7:5]);
        c6 = rd ? T6P[x] : T6N[x];
        r  = ($countones(c6) == 3) ? rd : ~rd;
        c4 = r ? T4P[y] : T4N[y];
        if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) ||
                       (r && (x == 11 || x == 13 || x == 14))))
            c4 = r ? 4'b1000 : 4'b0111;
        if ($countones(c4) != 2) r = ~r;
        return {r, c6, c4};
    endfunction

    // Timeline model: symbols occupy back-to-back SYM_CYC slots while enabled.
    logic       m_active = 1'b0;
    logic       m_rd     = 1'b0;
    logic       m_strobe = 1'b0;
    logic [9:0] m_code   = '0;
    int         m_phase  = 0;
    int         m_sym    = 0;
`ifdef SERIAL_TX_ERR_INJ_EN
    logic       m_armed    = 1'b0;
    logic       m_inj_prev = 1'b0;
`endif

    task automatic model_reset();
        m_active = 1'b0;
        m_rd     = 1'b0;
        m_strobe = 1'b0;
        m_phase  = 0;
        m_sym    = 0;
`ifdef SERIAL_TX_ERR_INJ_EN
        m_armed    = 1'b0;
        m_inj_prev = 1'b0;
`endif
    endtask

    task automatic model_step();
        logic [10:0] e;
        logic [7:0]  b;
`ifdef SERIAL_TX_ERR_INJ_EN
        logic        rise;
        rise       = bus.i_inj_err && !m_inj_prev;
        m_inj_prev = bus.i_inj_err;
`endif
        m_strobe = 1'b0;
        if (!m_active) begin
            if (bus.i_tx_en) begin
                m_active = 1'b1;
                m_phase  = 0;
                m_sym    = 0;
                m_code   = K_NEG;
                m_rd     = 1'b1;
                m_strobe = 1'b1;
            end
        end else if (m_phase == SYM_CYC - 1) begin
            m_phase = 0;
            if (!bus.i_tx_en) begin
                m_active = 1'b0;
                m_rd     = 1'b0;
            end else begin
                m_strobe = 1'b1;
                m_sym    = (m_sym + 1) % SPF;
                if (m_sym == 0) begin
                    m_code = m_rd ? K_POS : K_NEG;
                    m_rd   = ~m_rd;
                end else begin
                    b = m_byte(bus.i_IsPro, bus.i_IsMaster, bus.i_RawPls, bus.i_Option);
`ifdef SERIAL_TX_ERR_INJ_EN
                    if (m_armed) begin
                        b[0]    = ~b[0];
                        m_armed = 1'b0;
                        rise    = 1'b0;
                    end
`endif
                    e      = m_enc(b, m_rd);
                    m_code = e[9:0];
                    m_rd   = e[10];
                end
            end
        end else begin
            m_phase++;
        end
`ifdef SERIAL_TX_ERR_INJ_EN
        if (rise) m_armed = 1'b1;
`endif
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Independent decoder working only from the DUT line and strobe.
    logic       d_rd       = 1'b0;
    logic       d_first    = 1'b1;
    logic [9:0] d_word     = '0;
    int         d_cnt      = -1;
    int         last_comma = -1;
    int         n_par_bad  = 0;

    task automatic decode_symbol();
        logic [10:0] e;
        logic [7:0]  b;
        logic        found;
        logic        nrd;
        found = 1'b0;
        b     = '0;
        nrd   = d_rd;
        if (d_first) check("first_symbol_rdneg_comma", d_word, K_NEG);
        d_first = 1'b0;
        if (d_word == K_NEG || d_word == K_POS) begin
            check("comma_polarity", d_word, d_rd ? K_POS : K_NEG);
            if (last_comma >= 0) check("comma_spacing", cyc - last_comma, SPF * SYM_CYC);
            last_comma = cyc;
            d_rd       = ~d_rd;
        end else begin
            for (int v = 0; v < 256; v++) begin
                e = m_enc(8'(v), d_rd);
                if (!found && e[9:0] == d_word) begin
                    found = 1'b1;
                    b     = 8'(v);
                    nrd   = e[10];
                end
            end
            check("decode_code_and_disparity", found, 1'b1);
            if (found) begin
                d_rd = nrd;
                if (!(^b[7:4]) || !(^b[3:0])) n_par_bad++;
            end
        end
    endtask

    task automatic monitor();
        if (bus.o_tx_dis) begin
            d_cnt      = -1;
            d_rd       = 1'b0;
            d_first    = 1'b1;
            last_comma = -1;
        end else begin
            if (bus.o_sym_strobe) begin
                d_cnt  = 0;
                d_word = '0;
            end
            if (d_cnt >= 0) begin
                if (d_cnt % CPB == 0) d_word = {d_word[8:0], bus.o_SerialData};
                if (d_cnt == SYM_CYC - 1) begin
                    decode_symbol();
                    d_cnt = -1;
                end else begin
                    d_cnt++;
                end
            end
        end
    endtask

    initial forever begin
        logic [9:0] code;
        @(negedge clk);
        cyc++;
        code = m_code;
        check("line", bus.o_SerialData, m_active ? code[9 - m_phase / CPB] : 1'b0);
        check("tx_dis", bus.o_tx_dis, !m_active);
        check("tx_led", bus.o_tx_led, m_active);
        check("sym_strobe", bus.o_sym_strobe, m_strobe);
        monitor();
    end

    task automatic rand_payload();
        bus.i_IsPro    = 1'($urandom_range(0, 1));
        bus.i_IsMaster = 1'($urandom_range(0, 1));
        bus.i_RawPls   = 1'($urandom_range(0, 1));
        bus.i_Option   = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int waited;
        bus.i_tx_en    = 1'b0;
        bus.i_IsPro    = 1'b0;
        bus.i_IsMaster = 1'b0;
        bus.i_RawPls   = 1'b0;
        bus.i_Option   = 3'd0;
        bus.i_inj_err  = 1'b0;

        // Hand-computed codes pinning the model tables.
        check("pin_byte_e1", m_byte(1'b1, 1'b1, 1'b1, 3'd0), 8'hE1);
        check("pin_d0_0", m_enc(8'h00, 1'b0), {1'b0, 10'b1001110100});
        check("pin_d1_7", m_enc(8'hE1, 1'b0), {1'b0, 10'b0111010001});
        check("pin_d17_a7", m_enc(8'hF1, 1'b0), {1'b1, 10'b1000110111});
        check("pin_d21_5", m_enc(8'hB5, 1'b1), {1'b1, 10'b1010101010});

        repeat (3) @(negedge clk);
        check("rst_line", bus.o_SerialData, 1'b0);
        check("rst_tx_dis", bus.o_tx_dis, 1'b1);
        check("rst_strobe", bus.o_sym_strobe, 1'b0);
        check("rst_led", bus.o_tx_led, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Fixed payload over three frames.
        bus.i_IsPro    = 1'b1;
        bus.i_IsMaster = 1'b1;
        bus.i_RawPls   = 1'b1;
        bus.i_tx_en    = 1'b1;
        @(negedge clk);
        check("first_strobe", bus.o_sym_strobe, 1'b1);
        check("first_bit_a", bus.o_SerialData, 1'b0);
        check("first_tx_dis", bus.o_tx_dis, 1'b0);
        repeat (3 * SPF * SYM_CYC + SYM_CYC) @(negedge clk);

        // Random payload with RawPls toggling mid-symbol.
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) rand_payload();
            if ($urandom_range(0, 7) == 0) bus.i_RawPls = ~bus.i_RawPls;
        end

        // Enable dropped mid-stream, then restarted.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(100, 600)) @(negedge clk);
            bus.i_tx_en = 1'b0;
            waited      = 0;
            while (!bus.o_tx_dis && waited < 2 * SYM_CYC) begin
                @(negedge clk);
                waited++;
            end
            check("drop_completes_symbol", (waited <= SYM_CYC) && bus.o_tx_dis, 1'b1);
            check("idle_line_low", bus.o_SerialData, 1'b0);
            repeat (20) @(negedge clk);
            rand_payload();
            bus.i_tx_en = 1'b1;
        end

        // Two injection pulses inside one symbol: at most one corrupted data symbol.
        waited = 0;
        while (!bus.o_sym_strobe && waited < 2 * SYM_CYC) begin
            @(negedge clk);
            waited++;
        end
        check("strobe_before_inject", bus.o_sym_strobe, 1'b1);
        repeat (4) @(negedge clk);
        bus.i_inj_err = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_inj_err = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_inj_err = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_inj_err = 1'b0;
        repeat (60 * SYM_CYC) @(negedge clk);
        check("parity_errors_seen", n_par_bad, EXP_PAR);

        // Reset asserted between clock edges.
        repeat (57) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbit_rst_line", bus.o_SerialData, 1'b0);
        check("midbit_rst_tx_dis", bus.o_tx_dis, 1'b1);
        check("midbit_rst_strobe", bus.o_sym_strobe, 1'b0);
        check("midbit_rst_led", bus.o_tx_led, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SYM_CYC) @(negedge clk);
        check("restart_after_reset_strobe_seen", bus.o_tx_led, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
